// File: rtl/drp_reconf_seq.sv
`default_nettype none
// ============================================================================
//  Module   : drp_reconf_seq
//  Purpose  : PLL dynamic-reconfiguration sequencer. On SEN it holds the PLL
//             in reset, walks one of two host-loaded register tables doing a
//             read-modify-write on every DRP register, then releases reset and
//             waits for LOCKED.
//  Ports    : DCLK/RST        clock, synchronous active-high reset
//             SEN/SADDR       start strobe and bank select (IDLE only)
//             TBL_WE/ADDR/DATA table load port {daddr,mask,data} (IDLE only)
//             LOCKED          PLL lock indicator
//             DADDR/DEN/DWE/DI/DO/DRDY  DRP master interface
//             PLL_RST         PLL core reset
//             BUSY/SRDY/ERR   status: running, done pulse, sticky error
//  Options  : DRP_TIMEOUT_EN  adds a DRDY completion watchdog (TIMEOUT)
//  Revision : 1.0  initial release
// ============================================================================
module drp_reconf_seq #(
    parameter int ENTRIES   = 23,
    parameter int LOCK_WAIT = 1024
`ifdef DRP_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 64
`endif
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        SEN,
    input  logic        SADDR,
    input  logic        TBL_WE,
    input  logic [5:0]  TBL_ADDR,
    input  logic [38:0] TBL_DATA,
    input  logic        LOCKED,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    output logic        PLL_RST,
    output logic        BUSY,
    output logic        SRDY,
    output logic        ERR
);

    localparam int                  c_lock_w    = $clog2(LOCK_WAIT + 1);
    localparam logic [5:0]          c_entries   = 6'(ENTRIES);
    localparam logic [4:0]          c_last_idx  = 5'(ENTRIES - 1);
    localparam logic [c_lock_w-1:0] c_lock_last = c_lock_w'(LOCK_WAIT - 1);
`ifdef DRP_TIMEOUT_EN
    localparam int                  c_tmo_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last  = c_tmo_w'(TIMEOUT - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ASSERT_RST = 4'd1,
        S_READ       = 4'd2,
        S_WAIT_R     = 4'd3,
        S_MODIFY     = 4'd4,
        S_WRITE      = 4'd5,
        S_WAIT_W     = 4'd6,
        S_NEXT       = 4'd7,
        S_RELEASE    = 4'd8,
        S_WAIT_LOCK  = 4'd9,
        S_ERROR      = 4'd10
    } state_t;

    state_t                r_state;
    state_t                w_next;

    // Table storage is deliberately not reset so a mid-run RST keeps it.
    logic [38:0]           r_tbl [2][ENTRIES];

    logic                  r_bank;
    logic [4:0]            r_idx;
    logic [15:0]           r_rdata;
    logic                  r_seen;
    logic [c_lock_w-1:0]   r_lock_cnt;
    logic [6:0]            r_daddr;
    logic                  r_den;
    logic                  r_dwe;
    logic [15:0]           r_di;
    logic                  r_pll_rst;
    logic                  r_busy;
    logic                  r_srdy;
    logic                  r_err;

    logic                  w_last;
    logic                  w_done;
    logic                  w_tmo;
    logic                  w_lock_tmo;
    logic                  w_pll_rst;
    logic [4:0]            w_rd_idx;
    logic [6:0]            w_rd_daddr;
    logic [15:0]           w_mask;
    logic [15:0]           w_data;

`ifdef DRP_TIMEOUT_EN
    logic [c_tmo_w-1:0]    r_tmo_cnt;
`endif

    assign w_last     = (r_idx == c_last_idx);
    // A transaction completes on the first DRDY high after DRDY has dropped.
    assign w_done     = DRDY && r_seen;
    assign w_lock_tmo = !LOCKED && (r_lock_cnt == c_lock_last);

`ifdef DRP_TIMEOUT_EN
    assign w_tmo      = !w_done && (r_tmo_cnt == c_tmo_last);
`else
    assign w_tmo      = 1'b0;
`endif

    // DADDR is registered on entry to READ, so when leaving NEXT the address
    // must come from the index that READ is about to use.
    assign w_rd_idx   = (r_state == S_NEXT && !w_last) ? r_idx + 5'd1 : r_idx;
    assign w_rd_daddr = r_tbl[r_bank][w_rd_idx][38:32];
    assign w_mask     = r_tbl[r_bank][r_idx][31:16];
    assign w_data     = r_tbl[r_bank][r_idx][15:0];

    // ------------------------------------------------------------------
    // Table load port
    // ------------------------------------------------------------------
    always_ff @(posedge DCLK) begin
        if (!RST && r_state == S_IDLE && TBL_WE &&
            ({1'b0, TBL_ADDR[4:0]} < c_entries)) begin
            r_tbl[TBL_ADDR[5]][TBL_ADDR[4:0]] <= TBL_DATA;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge DCLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next value of PLL reset
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_pll_rst = 1'b0;
        case (r_state)
            S_IDLE:       if (SEN) w_next = S_ASSERT_RST;
            S_ASSERT_RST: w_next = S_READ;
            S_READ:       w_next = S_WAIT_R;
            S_WAIT_R: begin
                if (w_done)     w_next = S_MODIFY;
                else if (w_tmo) w_next = S_ERROR;
            end
            S_MODIFY:     w_next = S_WRITE;
            S_WRITE:      w_next = S_WAIT_W;
            S_WAIT_W: begin
                if (w_done)     w_next = S_NEXT;
                else if (w_tmo) w_next = S_ERROR;
            end
            S_NEXT:       w_next = w_last ? S_RELEASE : S_READ;
            S_RELEASE:    w_next = S_WAIT_LOCK;
            S_WAIT_LOCK:  if (LOCKED || w_lock_tmo) w_next = S_IDLE;
            S_ERROR:      w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase

        // PLL stays in reset from ASSERT_RST through the last NEXT, and for
        // the single ERROR cycle.
        case (w_next)
            S_ASSERT_RST, S_READ, S_WAIT_R, S_MODIFY,
            S_WRITE, S_WAIT_W, S_NEXT, S_ERROR: w_pll_rst = 1'b1;
            default:                            w_pll_rst = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge DCLK) begin
        if (RST) begin
            r_bank     <= 1'b0;
            r_idx      <= 5'd0;
            r_rdata    <= 16'd0;
            r_seen     <= 1'b0;
            r_lock_cnt <= '0;
            r_daddr    <= 7'd0;
            r_den      <= 1'b0;
            r_dwe      <= 1'b0;
            r_di       <= 16'd0;
            r_pll_rst  <= 1'b0;
            r_busy     <= 1'b0;
            r_srdy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_den     <= (w_next == S_READ) || (w_next == S_WRITE);
            r_dwe     <= (w_next == S_WRITE);
            r_busy    <= (w_next != S_IDLE);
            r_pll_rst <= w_pll_rst;
            r_srdy    <= (r_state == S_WAIT_LOCK) && LOCKED;

            if (w_next == S_READ) begin
                r_daddr <= w_rd_daddr;
            end

            case (r_state)
                S_IDLE: begin
                    if (SEN) begin
                        r_bank <= SADDR;
                        r_idx  <= 5'd0;
                        r_err  <= 1'b0;
                    end
                end
                S_READ, S_WRITE: r_seen <= 1'b0;
                S_WAIT_R: begin
                    if (!DRDY) begin
                        r_rdata <= DO;
                        r_seen  <= 1'b1;
                    end
                end
                S_WAIT_W: begin
                    if (!DRDY) r_seen <= 1'b1;
                end
                // Mask bit set keeps the bit read back from the PLL.
                S_MODIFY: r_di <= (r_rdata & w_mask) | (w_data & ~w_mask);
                S_NEXT: begin
                    if (!w_last) r_idx <= r_idx + 5'd1;
                end
                S_RELEASE: r_lock_cnt <= '0;
                S_WAIT_LOCK: begin
                    if (!LOCKED)    r_lock_cnt <= r_lock_cnt + 1'b1;
                    if (w_lock_tmo) r_err      <= 1'b1;
                end
                default: ;
            endcase

            if ((r_state == S_WAIT_R || r_state == S_WAIT_W) && w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef DRP_TIMEOUT_EN
    // Watchdog counts from the DEN cycle; reaching TIMEOUT-1 in a wait state
    // without completion means TIMEOUT cycles have elapsed since DEN.
    always_ff @(posedge DCLK) begin
        if (RST) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_READ || r_state == S_WRITE) begin
            r_tmo_cnt <= c_tmo_w'(1);
        end else if (r_state == S_WAIT_R || r_state == S_WAIT_W) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`endif

    assign DADDR   = r_daddr;
    assign DEN     = r_den;
    assign DWE     = r_dwe;
    assign DI      = r_di;
    assign PLL_RST = r_pll_rst;
    assign BUSY    = r_busy;
    assign SRDY    = r_srdy;
    assign ERR     = r_err;

endmodule
`default_nettype wire
